// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller:
// the ID-stage operand/destination info in, and the stall/flush controls and perf counters out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_rd;
    logic             id_writes_rd;
    logic             mem_branch_taken;

    logic             pc_hold;
    logic             if_id_hold;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [1:0]       hazard_stage;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, mem_branch_taken,
        input  pc_hold, if_id_hold, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_flush, hazard_stage, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, mem_branch_taken,
        output pc_hold, if_id_hold, id_ex_bubble, if_id_flush, id_ex_flush,
               ex_mem_flush, hazard_stage, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// RAW interlock and taken-branch flush controller for a 5-stage in-order pipeline,
// built on a 3-entry destination-register scoreboard (EX, MEM, WB).
module pipe_hazard_ctrl #(
    parameter int WB_BYPASS = 0,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Index 0 = EX (youngest), 1 = MEM, 2 = WB.
    logic [2:0] sb_v_reg;
    logic [4:0] sb_rd_reg [3];

    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] flush_count_reg;

    logic [2:0] match_rs1;
    logic [2:0] match_rs2;
    logic [2:0] hit;
    logic       hazard;
    logic [1:0] state_next;
    logic [1:0] stage_next;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
            // A write-first regfile makes the WB writer visible to ID, so it never blocks.
            localparam bit EXCLUDED = (gi == 2) && (WB_BYPASS != 0);
            assign match_rs1[gi] = !EXCLUDED && sb_v_reg[gi] &&
                                   (sb_rd_reg[gi] == bus.id_rs1) && (bus.id_rs1 != 5'd0);
            assign match_rs2[gi] = !EXCLUDED && sb_v_reg[gi] &&
                                   (sb_rd_reg[gi] == bus.id_rs2) && (bus.id_rs2 != 5'd0);
            assign hit[gi] = (bus.id_uses_rs1 && match_rs1[gi]) ||
                             (bus.id_uses_rs2 && match_rs2[gi]);
        end
    endgenerate

    assign hazard = bus.id_valid && (hit != 3'b000);

    always_comb begin
        state_next = ST_RUN;
        if (!reset) begin
            if (bus.mem_branch_taken) begin
                state_next = ST_FLUSH;
            end else if (hazard) begin
                state_next = ST_STALL;
            end
        end
    end

    always_comb begin
        stage_next = 2'd0;
        if (!reset && hazard) begin
            if (hit[0]) begin
                stage_next = 2'd1;
            end else if (hit[1]) begin
                stage_next = 2'd2;
            end else begin
                stage_next = 2'd3;
            end
        end
    end

    assign bus.pc_hold      = (state_next == ST_STALL);
    assign bus.if_id_hold   = (state_next == ST_STALL);
    assign bus.id_ex_bubble = (state_next == ST_STALL);
    assign bus.if_id_flush  = (state_next == ST_FLUSH);
    assign bus.id_ex_flush  = (state_next == ST_FLUSH);
    assign bus.ex_mem_flush = (state_next == ST_FLUSH);
    assign bus.hazard_stage = stage_next;
    assign bus.stall_count  = stall_count_reg;
    assign bus.flush_count  = flush_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_v_reg        <= 3'b000;
            sb_rd_reg[0]    <= 5'd0;
            sb_rd_reg[1]    <= 5'd0;
            sb_rd_reg[2]    <= 5'd0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            sb_v_reg[2]  <= sb_v_reg[1];
            sb_rd_reg[2] <= sb_rd_reg[1];
            // A flush kills the instruction leaving EX, so it never reaches MEM.
            sb_v_reg[1]  <= (state_next == ST_FLUSH) ? 1'b0 : sb_v_reg[0];
            sb_rd_reg[1] <= sb_rd_reg[0];
            sb_v_reg[0]  <= (state_next == ST_RUN) &&
                            bus.id_valid && bus.id_writes_rd && (bus.id_rd != 5'd0);
            sb_rd_reg[0] <= bus.id_rd;
            if (state_next == ST_STALL) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (state_next == ST_FLUSH) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl; runs a WB_BYPASS=0 and a
// WB_BYPASS=1 instance side by side on identical ID-stage stimulus.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus0 ();
    pipe_hazard_ctrl_if #(.CNT_W(32)) bus1 ();

    pipe_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pipe_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(32)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       br;
        // expectations, sampled before the edge of this cycle
        logic       hold0;
        logic [1:0] stage0;
        int         stall0;
        logic       hold1;
        logic [1:0] stage1;
        int         stall1;
        logic       flush;
        int         flushes;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus0.id_valid = v.valid;  bus1.id_valid = v.valid;
        bus0.id_rs1 = v.rs1;      bus1.id_rs1 = v.rs1;
        bus0.id_rs2 = v.rs2;      bus1.id_rs2 = v.rs2;
        bus0.id_uses_rs1 = v.u1;  bus1.id_uses_rs1 = v.u1;
        bus0.id_uses_rs2 = v.u2;  bus1.id_uses_rs2 = v.u2;
        bus0.id_rd = v.rd;        bus1.id_rd = v.rd;
        bus0.id_writes_rd = v.wr; bus1.id_writes_rd = v.wr;
        bus0.mem_branch_taken = v.br;
        bus1.mem_branch_taken = v.br;
    endtask

    function automatic vec_t mk(input logic valid, input int rs1, input int rs2,
                                input logic u1, input logic u2, input int rd,
                                input logic wr, input logic br,
                                input logic hold0, input int stage0, input int stall0,
                                input logic hold1, input int stage1, input int stall1,
                                input logic flush, input int flushes);
        vec_t v;
        v.valid = valid; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
        v.rd = 5'(rd); v.wr = wr; v.br = br;
        v.hold0 = hold0; v.stage0 = 2'(stage0); v.stall0 = stall0;
        v.hold1 = hold1; v.stage1 = 2'(stage1); v.stall1 = stall1;
        v.flush = flush; v.flushes = flushes;
        return v;
    endfunction

    task automatic check_ctrl0(input string tag, input int idx, input logic hold,
                               input logic flush, input int stage);
        chk({tag, ".pc_hold"},      idx, int'(bus0.pc_hold),      int'(hold));
        chk({tag, ".if_id_hold"},   idx, int'(bus0.if_id_hold),   int'(hold));
        chk({tag, ".id_ex_bubble"}, idx, int'(bus0.id_ex_bubble), int'(hold));
        chk({tag, ".if_id_flush"},  idx, int'(bus0.if_id_flush),  int'(flush));
        chk({tag, ".id_ex_flush"},  idx, int'(bus0.id_ex_flush),  int'(flush));
        chk({tag, ".ex_mem_flush"}, idx, int'(bus0.ex_mem_flush), int'(flush));
        chk({tag, ".hazard_stage"}, idx, int'(bus0.hazard_stage), stage);
    endtask

    initial begin
        //            val rs1 rs2 u1 u2 rd wr br | h0 s0 st0 | h1 s1 st1 | fl nfl
        tbl[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0,   0, 0, 0,   0, 0, 0,   0, 0); // add x5
        tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0,   1, 1, 0,   1, 1, 0,   0, 0); // add x6,x5,x1
        tbl[2]  = mk(1, 5, 1, 1, 1, 6, 1, 0,   1, 2, 1,   1, 2, 1,   0, 0);
        tbl[3]  = mk(1, 5, 1, 1, 1, 6, 1, 0,   1, 3, 2,   0, 0, 2,   0, 0);
        tbl[4]  = mk(1, 5, 1, 1, 1, 6, 1, 0,   0, 0, 3,   0, 0, 2,   0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3,   0, 0, 2,   0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3,   0, 0, 2,   0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 3,   0, 0, 2,   0, 0);
        tbl[8]  = mk(1, 1, 2, 1, 1, 0, 1, 0,   0, 0, 3,   0, 0, 2,   0, 0); // writes x0
        tbl[9]  = mk(1, 0, 0, 1, 1, 3, 1, 0,   0, 0, 3,   0, 0, 2,   0, 0); // reads x0
        tbl[10] = mk(1, 1, 2, 1, 1, 7, 1, 0,   0, 0, 3,   0, 0, 2,   0, 0); // add x7
        tbl[11] = mk(1, 1, 2, 1, 1, 8, 1, 0,   0, 0, 3,   0, 0, 2,   0, 0); // independent
        tbl[12] = mk(1, 7, 0, 1, 0, 9, 1, 0,   1, 2, 3,   1, 2, 2,   0, 0); // uses x7
        tbl[13] = mk(1, 7, 0, 1, 0, 9, 1, 0,   1, 3, 4,   0, 0, 3,   0, 0);
        tbl[14] = mk(1, 7, 0, 1, 0, 9, 1, 0,   0, 0, 5,   0, 0, 3,   0, 0);
        tbl[15] = mk(1, 9, 0, 1, 0, 10, 1, 1,  0, 1, 5,   0, 1, 3,   1, 0); // hazard + branch
        tbl[16] = mk(1, 9, 0, 1, 0, 10, 1, 0,  0, 0, 5,   0, 0, 3,   0, 1); // x9 squashed
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 5,   0, 0, 3,   1, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 5,   0, 0, 3,   1, 2); // back-to-back
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 5,   0, 0, 3,   0, 3);

        // Reset with a branch and a would-be hazard on the inputs: everything stays quiet.
        drive(mk(1, 5, 5, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_ctrl0("rst", -1, 1'b0, 1'b0, 0);
        chk("rst.stall_count", -1, int'(bus0.stall_count), 0);
        chk("rst.flush_count", -1, int'(bus0.flush_count), 0);
        chk("rst.pc_hold1", -1, int'(bus1.pc_hold), 0);
        $display("reset: pc_hold=%0d flush=%0d stage=%0d", bus0.pc_hold, bus0.if_id_flush,
                 bus0.hazard_stage);
        @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = 1'b0;
            drive(tbl[i]);
            #1;
            check_ctrl0("wb0", i, tbl[i].hold0, tbl[i].flush, int'(tbl[i].stage0));
            chk("wb0.stall_count", i, int'(bus0.stall_count), tbl[i].stall0);
            chk("wb0.flush_count", i, int'(bus0.flush_count), tbl[i].flushes);
            chk("wb1.pc_hold", i, int'(bus1.pc_hold), int'(tbl[i].hold1));
            chk("wb1.ex_mem_flush", i, int'(bus1.ex_mem_flush), int'(tbl[i].flush));
            chk("wb1.hazard_stage", i, int'(bus1.hazard_stage), int'(tbl[i].stage1));
            chk("wb1.stall_count", i, int'(bus1.stall_count), tbl[i].stall1);
            $display("vec %0d: hold=%0d/%0d stage=%0d/%0d flush=%0d stalls=%0d/%0d flushes=%0d",
                     i, bus0.pc_hold, bus1.pc_hold, bus0.hazard_stage, bus1.hazard_stage,
                     bus0.if_id_flush, bus0.stall_count, bus1.stall_count, bus0.flush_count);
        end

        // Reset arriving in the 2nd cycle of a 3-cycle stall.
        @(negedge clk);
        drive(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_ctrl0("rs.prod", 0, 1'b0, 1'b0, 0);
        $display("rs prod: hold=%0d", bus0.pc_hold);
        @(negedge clk);
        drive(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_ctrl0("rs.stall1", 1, 1'b1, 1'b0, 1);
        chk("rs.stall1.count", 1, int'(bus0.stall_count), 5);
        $display("rs stall1: hold=%0d stage=%0d", bus0.pc_hold, bus0.hazard_stage);
        @(negedge clk);
        #1;
        check_ctrl0("rs.stall2", 2, 1'b1, 1'b0, 2);
        reset = 1'b1;
        #1;
        check_ctrl0("rs.in_reset", 2, 1'b0, 1'b0, 0);
        $display("rs in reset: hold=%0d stage=%0d", bus0.pc_hold, bus0.hazard_stage);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_ctrl0("rs.after", 3, 1'b0, 1'b0, 0);
        chk("rs.after.stall_count", 3, int'(bus0.stall_count), 0);
        chk("rs.after.flush_count", 3, int'(bus0.flush_count), 0);
        chk("rs.after.pc_hold1", 3, int'(bus1.pc_hold), 0);
        $display("rs after: hold=%0d stage=%0d stalls=%0d", bus0.pc_hold, bus0.hazard_stage,
                 bus0.stall_count);
        @(posedge clk);
        #1;
        chk("rs.after.edge.stall_count", 4, int'(bus0.stall_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
